// File: rtl/cla_pkg.sv
// cla_pkg: shared constants, state encoding and helpers for the sequenced CLA adder
package cla_pkg;
  localparam int SLICE_W = 10;
  localparam int NSLICE = 4;
  localparam int W = SLICE_W * NSLICE;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int idx_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  localparam int IDX_W = idx_width(NSLICE);
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational N-bit carry-lookahead adder slice
module cla_slice #(
  parameter int N = 10
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;
  assign g = a & b;
  assign p = a ^ b;
  // every carry is expanded from g, p and ci directly rather than rippled from c[i]
  always_comb begin
    c = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      logic acc;
      logic pp;
      acc = g[i];
      pp = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp = pp & p[j];
      end
      c[i+1] = acc | (pp & ci);
    end
  end
  assign s = p ^ c[N-1:0];
  assign co = c[N];
endmodule

// File: rtl/cla_seq_ctrl.sv
// cla_seq_ctrl: wide adder that time-shares one CLA slice, least-significant slice first
module cla_seq_ctrl #(
  parameter int SLICE_W = cla_pkg::SLICE_W,
  parameter int NSLICE = cla_pkg::NSLICE,
  localparam int W = SLICE_W * NSLICE
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_add1,
  input  logic [W-1:0] i_add2,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W:0]   o_result,
  output logic         o_busy
);
  import cla_pkg::*;
  localparam int IW = idx_width(NSLICE);
  state_t state;
  state_t state_n;
  logic [IW-1:0] idx;
  logic carry;
  logic [W-1:0] a_r;
  logic [W-1:0] b_r;
  logic [W-1:0] sum_r;
  logic [W-1:0] sum_n;
  logic [W:0] res;
  logic [SLICE_W-1:0] sa;
  logic [SLICE_W-1:0] sb;
  logic [SLICE_W-1:0] ss;
  logic co;
  logic last;
  assign last = idx == IW'(NSLICE - 1);
  assign sa = a_r[idx*SLICE_W +: SLICE_W];
  assign sb = b_r[idx*SLICE_W +: SLICE_W];
  cla_slice #(.N(SLICE_W)) u_slice (
    .a (sa),
    .b (sb),
    .ci(carry),
    .s (ss),
    .co(co)
  );
  always_comb begin
    sum_n = sum_r;
    sum_n[idx*SLICE_W +: SLICE_W] = ss;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    if (state == IDLE && i_valid) state_n = RUN;
    else if (state == RUN && last) state_n = DONE;
    else if (state == DONE && i_ready) state_n = IDLE;
  end
  always_comb begin
    o_ready = state == IDLE;
    o_valid = state == DONE;
    o_busy = state != IDLE;
    o_result = res;
  end
  // res is separate from sum_r so the last result survives the next accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      idx <= '0;
      carry <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      res <= '0;
    end else if (state == IDLE && i_valid) begin
      a_r <= i_add1;
      b_r <= i_add2;
      sum_r <= '0;
      carry <= 1'b0;
      idx <= '0;
    end else if (state == RUN) begin
      sum_r <= sum_n;
      carry <= co;
      idx <= last ? idx : idx + 1'b1;
      if (last) res <= {co, sum_n};
    end
  end
endmodule

// File: tb/tb_cla_seq_ctrl.sv
// tb_cla_seq_ctrl: directed and randomized checks of the sequenced adder against a+b
module tb_cla_seq_ctrl;
  localparam int W = 40;
  localparam int NSLICE = 4;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_valid = 1'b0;
  logic o_ready;
  logic [W-1:0] i_add1 = '0;
  logic [W-1:0] i_add2 = '0;
  logic o_valid;
  logic i_ready = 1'b0;
  logic [W:0] o_result;
  logic o_busy;
  int checks = 0;
  int errors = 0;
  always #5 i_clk = ~i_clk;
  cla_seq_ctrl dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_add1  (i_add1),
    .i_add2  (i_add2),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_result(o_result),
    .o_busy  (o_busy)
  );
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W:0] exp, input int hold);
    int n;
    i_add1 = a;
    i_add2 = b;
    i_valid = 1'b1;
    i_ready = 1'b0;
    check({tag, "_ready"}, 64'(o_ready), 64'd1);
    tick();
    i_add1 = ~a;
    i_add2 = ~b;
    i_valid = hold > 0;
    n = 0;
    while (!o_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(NSLICE));
    for (int k = 0; k < hold; k++) begin
      i_valid = k[0];
      i_ready = 1'b0;
      check({tag, "_hold_valid"}, 64'(o_valid), 64'd1);
      check({tag, "_hold_result"}, 64'(o_result), 64'(exp));
      tick();
    end
    i_valid = 1'b0;
    check({tag, "_result"}, 64'(o_result), 64'(exp));
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(o_valid), 64'd0);
    check({tag, "_ready_back"}, 64'(o_ready), 64'd1);
    check({tag, "_idle"}, 64'(o_busy), 64'd0);
  endtask
  initial begin
    logic [W:0] q[$];
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic acc;
    logic hs;
    int done;
    int accepted;
    int produced;
    int cyc;
    tick();
    tick();
    i_rst = 1'b0;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_result", 64'(o_result), 64'd0);
    run_op("zero", '0, '0, model('0, '0), 0);
    run_op("slice_carry", 40'h00000003FF, 40'h0000000001, 41'h00000000400, 0);
    run_op("full_ripple", 40'hFFFFFFFFFF, 40'h0000000001, 41'h10000000000, 0);
    run_op("stall", 40'h123456789A, 40'h0FEDCBA987, 41'h2222222221, 7);
    check("sticky_result", 64'(o_result), 64'h2222222221);
    i_add1 = '1;
    i_add2 = '1;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", 64'(o_busy), 64'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("abort_ready", 64'(o_ready), 64'd1);
    check("abort_valid", 64'(o_valid), 64'd0);
    check("abort_result", 64'(o_result), 64'd0);
    check("abort_busy", 64'(o_busy), 64'd0);
    tick();
    tick();
    tick();
    tick();
    check("abort_no_result", 64'(o_valid), 64'd0);
    i_valid = 1'b1;
    i_rst = 1'b1;
    tick();
    i_valid = 1'b0;
    i_rst = 1'b0;
    check("rst_beats_valid", 64'(o_busy), 64'd0);
    run_op("five_six", 40'd5, 40'd6, 41'd11, 0);
    done = 0;
    accepted = 0;
    produced = 0;
    cyc = 0;
    while (done < 1000 && cyc < 40000) begin
      ra = $urandom_range(0, 7) == 0 ? '1 : W'({$urandom, $urandom});
      rb = $urandom_range(0, 7) == 0 ? '1 : W'({$urandom, $urandom});
      i_add1 = ra;
      i_add2 = rb;
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 3) != 0;
      #1;
      acc = o_ready && i_valid;
      hs = o_valid && i_ready;
      if (o_valid) begin
        if (q.size() == 0) begin
          check("rand_spurious", 64'(o_valid), 64'd0);
        end else begin
          check("rand_result", 64'(o_result), 64'(q[0]));
        end
      end
      if (hs && q.size() > 0) begin
        void'(q.pop_front());
        produced++;
        done++;
      end
      if (acc) begin
        q.push_back(model(ra, rb));
        accepted++;
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) begin
      if (o_valid) begin
        check("drain_result", 64'(o_result), 64'(q[0]));
        void'(q.pop_front());
        produced++;
      end
      tick();
    end
    check("rand_done", 64'(done), 64'd1000);
    check("rand_one_per_op", 64'(produced), 64'(accepted));
    check("rand_queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
